// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter between the cpu
// data port and the secondary DMA/debug requester.
package dmem_pkg;

  localparam int unsigned AW_DEF           = 16;
  localparam int unsigned DW_DEF           = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 64;

  // Who issued the RAM read whose data appears on mem_rdata this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: the cpu always wins and is never stalled; the DMA
// port gets idle slots via req/gnt and is flagged when it waits too long.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_raddr,
  output logic [DW-1:0] cpu_rdata,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_starved,
  output logic          cpu_conflict,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  owner_t        rd_owner_q, rd_owner_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          dma_starved_q, dma_starved_d;
  logic          cpu_conflict_q, cpu_conflict_d;

  // Slot selection. Gated by rst so nothing reaches the RAM while held in reset.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    dma_gnt    = 1'b0;
    rd_owner_d = OWN_NONE;
    if (rst) begin
      if (cpu_we) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cpu_waddr;
        mem_wdata = cpu_wdata;
      end else if (cpu_re) begin
        mem_en     = 1'b1;
        mem_addr   = cpu_raddr;
        rd_owner_d = OWN_CPU;
      end else if (dma_req) begin
        mem_en    = 1'b1;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_gnt   = 1'b1;
        if (!dma_we) rd_owner_d = OWN_DMA;
      end
    end
  end

  always_comb begin
    cpu_conflict_d = cpu_conflict_q | (cpu_re & cpu_we);
    wait_cnt_d     = '0;
    if (dma_req && !dma_gnt)
      wait_cnt_d = (wait_cnt_q == LIMIT) ? wait_cnt_q : wait_cnt_q + CW'(1);
    dma_starved_d = (wait_cnt_d == LIMIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_q     <= OWN_NONE;
      cpu_conflict_q <= 1'b0;
    end else begin
      rd_owner_q     <= rd_owner_d;
      cpu_conflict_q <= cpu_conflict_d;
    end
  end

  // Starvation monitor: counts consecutive refused DMA cycles, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q    <= '0;
      dma_starved_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      dma_starved_q <= dma_starved_d;
    end
  end

  assign cpu_rdata    = mem_rdata;
  assign dma_rvalid   = (rd_owner_q == OWN_DMA);
  assign dma_rdata    = dma_rvalid ? mem_rdata : '0;
  assign dma_starved  = dma_starved_q;
  assign cpu_conflict = cpu_conflict_q;

endmodule
